// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode-side read bus and writeback-side write bus of reg_file_mp
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     Clear_Req;
    logic [NUM_RD*ADDR_W-1:0] Read_Reg;
    logic [NUM_RD*DATA_W-1:0] Read_Data;
    logic [ADDR_W-1:0]        Write_Reg;
    logic [DATA_W-1:0]        Write_Data;
    logic                     Reg_Write;
    logic                     Busy;
    modport master (
        output Clear_Req, Read_Reg, Write_Reg, Write_Data, Reg_Write,
        input  Read_Data, Busy
    );
    modport slave (
        input  Clear_Req, Read_Reg, Write_Reg, Write_Data, Reg_Write,
        output Read_Data, Busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: NUM_RD registered read ports, one write port, clear sequencer; define RF_BYPASS_EN for write-first reads
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic          Clock,
    input logic          Reset,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    logic [0:0]               state_q, state_d;
    logic [ADDR_W-1:0]        clr_addr_q, clr_addr_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     run, clr, we;
    logic [ADDR_W-1:0]        wa, ra;
    logic [DATA_W-1:0]        wd;
    always_comb begin
        run        = state_q == RUN;
        clr        = run && bus.Clear_Req;
        we         = run ? (bus.Reg_Write && !bus.Clear_Req && !(ZERO_REG != 0 && bus.Write_Reg == '0)) : 1'b1;
        wa         = run ? bus.Write_Reg : clr_addr_q;
        wd         = run ? bus.Write_Data : '0;
        state_d    = run ? (clr ? CLEAR : RUN) : (clr_addr_q == '1 ? RUN : CLEAR);
        clr_addr_d = run ? (clr ? '0 : clr_addr_q) : clr_addr_q + ADDR_W'(1);
        rd_data_d  = '0;
        ra         = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.Read_Reg[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
            rd_data_d[k*DATA_W +: DATA_W] = (!run || (ZERO_REG != 0 && ra == '0)) ? '0 :
                                            (we && ra == wa) ? wd : mem_q[ra];
`else
            rd_data_d[k*DATA_W +: DATA_W] = (!run || (ZERO_REG != 0 && ra == '0)) ? '0 : mem_q[ra];
`endif
        end
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end
    always_ff @(posedge Clock) begin
        if (!Reset && we) mem_q[wa] <= wd;
    end
    assign bus.Read_Data = rd_data_q;
    assign bus.Busy      = state_q == CLEAR;
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the single-cycle datapath and its successors. Provides DEPTH = 2^ADDR_W words of DATA_W bits, NUM_RD independent registered read ports and one write port. An optional hardwired zero register is supported. A built-in clear sequencer zeroes the array after reset or on request and flags Busy while doing so. Sits between instruction decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, word width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W words
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = address 0 always reads 0 and ignores writes; 0 = ordinary register
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Clear_Req  in  1  pulse: start clear sequence
- Read_Reg  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- Read_Data  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- Write_Reg  in  ADDR_W  write address
- Write_Data  in  DATA_W  write data
- Reg_Write  in  1  write enable
- Busy  out  1  clear sequence in progress; writes ignored, reads return 0

## Operation
- FSM states: CLEAR, RUN.
- Reset = 1 at an edge:
  - state <= CLEAR, clr_addr <= 0.
  - Read_Data <= 0, Busy <= 1.
  - Reset has priority over everything else.
- CLEAR:
  - Each cycle writes 0 to array[clr_addr], then clr_addr increments.
  - On the edge that writes DEPTH-1: state <= RUN and Busy <= 0.
  - A full clear takes DEPTH cycles after Reset deasserts.
  - Reg_Write and Clear_Req are ignored in CLEAR.
  - Read_Data is forced to 0 in CLEAR.
- RUN:
  - Clear_Req = 1: state <= CLEAR, clr_addr <= 0, Busy <= 1. Any Reg_Write in the same cycle is dropped.
  - Reg_Write = 1: array[Write_Reg] <= Write_Data. If ZERO_REG = 1 and Write_Reg = 0, the write is dropped.
  - Each port k: Read_Data[k] <= array[Read_Reg[k]] (0 if ZERO_REG and address 0).
  - Same-cycle write and read to the same address resolves per RF_BYPASS_EN (see Configuration).
- Ports are independent. Any ports may read the same address in the same cycle.
- No initial values: contents are defined only by the clear sequence and writes.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on Read_Data after edge N and holds until the next edge.
- Write latency: a write at edge N is visible to a read sampled at edge N+1 regardless of configuration.
- Busy:
  - Rises on the edge that samples Reset or an accepted Clear_Req.
  - Falls on the edge that clears word DEPTH-1.
- Reset held high for multiple cycles: clr_addr stays at 0 and Busy stays 1. The clear sequence begins on the first edge with Reset = 0.
- Reset during CLEAR: the sequence restarts from address 0.
- Reset values: Read_Data = 0 on all ports, Busy = 1.

## Configuration
- RF_BYPASS_EN defined:
  - In RUN, if Reg_Write = 1, the write is not dropped, and Read_Reg[k] = Write_Reg, then Read_Data[k] <= Write_Data (write-first).
  - A zero-register read still returns 0.
- RF_BYPASS_EN undefined:
  - Same-cycle read returns the old array contents (read-first).
  - The new value appears from the next read onward.

## Test plan
- Reset 1 cycle, then idle -> Busy = 1 for exactly 32 cycles (defaults). Afterwards all 32 addresses read 0 on both ports.
- Write 0xDEADBEEF to reg 17, then read ports 0/1 at 17/17 next cycle -> both return 0xDEADBEEF one cycle later. Write 0x1 to reg 0 -> reg 0 reads 0 (ZERO_REG = 1).
- Write 0x12345678 to reg 5 while port 0 reads reg 5 in the same cycle:
  - With RF_BYPASS_EN -> port 0 returns 0x12345678.
  - Without RF_BYPASS_EN -> port 0 returns the prior value 0x0.
- After filling regs 1..31 with their index, pulse Clear_Req together with a Reg_Write to reg 3 -> write dropped, Busy high for 32 cycles, then reg 3 and reg 31 read 0.
- Assert Reset at clr_addr = 10 during a clear -> Busy stays high, and the clear completes 32 cycles after Reset deasserts.
- NUM_RD = 4, DATA_W = 16, ADDR_W = 3 -> four ports reading regs 1, 2, 1, 7 after writes 0xAAAA / 0x5555 / 0x00FF return 0xAAAA, 0x5555, 0xAAAA, 0x00FF. Clear takes 8 cycles.
